decode_stage: RTL and testbench

- Registered, parametrised RV32I/RV64I decode stage between fetch and execute.
- Accepts raw instruction words with their PC over a valid/ready handshake.
- Decodes opcode, funct fields, register indices, an XLEN-wide sign-extended immediate and an illegal-instruction flag.
- Buffers decoded results in a DEPTH-entry FIFO so execute stalls do not immediately back-pressure fetch; supports pipeline flush.

---
 rtl/decode_stage_pkg.sv | 68 ++++++
 rtl/decode_stage_comb.sv | 84 ++++++++
 rtl/decode_stage.sv | 98 +++++++++
 tb/tb_decode_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: RV32I/RV64I encoding constants and immediate helpers shared by the decode stage
package decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SR    = 3'b101;
    localparam logic [2:0] F3_FENCE = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    // Every format fits in 32 bits; callers sign-extend the result to XLEN.
    function automatic logic [31:0] imm32(input imm_fmt_e fmt, input logic [31:0] i);
        case (fmt)
            IMM_I:   imm32 = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm32 = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm32 = {i[31:12], 12'b0};
            IMM_J:   imm32 = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: imm32 = 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// decode_comb: purely combinational immediate generation and illegal-instruction detection
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ENABLE_M     = 0,
    parameter int ENABLE_FENCE = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       op_bad;
    logic       sh_bad;
    logic       shw_bad;
    logic       bad;
    imm_fmt_e   fmt;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // Sub-checks shared by several opcodes; RV64 shifts use funct6 so shamt[5] may be set
    always_comb begin
        op_bad  = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) ||
                    (ENABLE_M != 0 && f7 == F7_MULDIV));
        sh_bad  = RV64 ? (f3 == F3_SLL ? instr[31:26] != 6'b000000 :
                          f3 == F3_SR  ? !(instr[31:26] inside {6'b000000, 6'b010000}) : 1'b0)
                       : (f3 == F3_SLL ? f7 != F7_BASE :
                          f3 == F3_SR  ? !(f7 inside {F7_BASE, F7_ALT}) : 1'b0);
        shw_bad = f3 == F3_ADD ? 1'b0 :
                  f3 == F3_SLL ? f7 != F7_BASE :
                  f3 == F3_SR  ? !(f7 inside {F7_BASE, F7_ALT}) : 1'b1;
    end

    // Classify opcode into immediate format and legality; illegal words carry no immediate
    always_comb begin
        fmt = IMM_NONE;
        bad = 1'b0;
        case (opc)
            OPC_LOAD: begin
                fmt = IMM_I;
                bad = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU} ||
                        (RV64 && f3 inside {F3_LD, F3_LWU}));
            end
            OPC_STORE: begin
                fmt = IMM_S;
                bad = f3 > (RV64 ? F3_SD : F3_SW);
            end
            OPC_BRANCH: begin
                fmt = IMM_B;
                bad = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
            end
            OPC_JALR: begin
                fmt = IMM_I;
                bad = f3 != 3'b000;
            end
            OPC_JAL:           fmt = IMM_J;
            OPC_LUI, OPC_AUIPC: fmt = IMM_U;
            OPC_OP_IMM: begin
                fmt = IMM_I;
                bad = sh_bad;
            end
            OPC_OP_IMM_32: begin
                fmt = IMM_I;
                bad = !RV64 || shw_bad;
            end
            OPC_OP:       bad = op_bad;
            OPC_OP_32:    bad = !RV64 || op_bad;
            OPC_MISC_MEM: bad = f3 != F3_FENCE || ENABLE_FENCE == 0;
            OPC_SYSTEM:   fmt = f3[1:0] != 2'b00 ? IMM_I : IMM_NONE;
            default:      bad = 1'b1;
        endcase
        illegal = bad || instr[1:0] != 2'b11;
        imm     = illegal ? '0 : XLEN'($signed(imm32(fmt, instr)));
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage buffering decoded instructions in a small FIFO
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int ENABLE_M     = 0,
    parameter int ENABLE_FENCE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = XLEN + 32 + XLEN + 1;

    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [EW-1:0]   last_q, last_d;
    logic [EW-1:0]   head;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    logic            push;
    logic            pop;

    decode_comb #(
        .XLEN         (XLEN),
        .ENABLE_M     (ENABLE_M),
        .ENABLE_FENCE (ENABLE_FENCE)
    ) u_comb (
        .instr   (in_instr),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign in_ready  = count_q != (AW+1)'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // When empty the outputs replay the last presented entry so they never go undefined
    assign head = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign {out_pc, head_instr, out_imm, out_illegal} = head;
    assign out_opcode = head_instr[6:0];
    assign out_rd     = head_instr[11:7];
    assign out_func3  = head_instr[14:12];
    assign out_rs1    = head_instr[19:15];
    assign out_rs2    = head_instr[24:20];
    assign out_func7  = head_instr[31:25];

    // Next-state for pointers, occupancy and storage; flush discards everything in flight
    always_comb begin
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = {in_pc, in_instr, dec_imm, dec_ill};
        last_d   = head;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench driving an RV32 and an RV64(M) decode stage with directed vectors
module tb_decode_stage;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm32;
        logic        ill32;
        logic [63:0] imm64;
        logic        ill64;
    } vec_t;

    logic clk = 1'b0;
    logic rn;
    logic fl32, fl64;
    logic iv32, iv64, ir32, ir64;
    logic [31:0] ins32, ins64;
    logic [31:0] ipc32;
    logic [63:0] ipc64;
    logic ov32, ov64, ordy32, ordy64;
    logic [31:0] opc32, oimm32;
    logic [63:0] opc64, oimm64;
    logic [6:0] oop32, oop64, of7_32, of7_64;
    logic [2:0] of3_32, of3_64;
    logic [4:0] ors1_32, ors1_64, ors2_32, ors2_64, ord32, ord64;
    logic oill32, oill64;

    int total = 0;
    int bad = 0;
    logic [63:0] nxt_pc = 64'h1000;
    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .DEPTH(2), .ENABLE_M(0), .ENABLE_FENCE(1)) u32 (
        .clk(clk), .reset_n(rn), .flush(fl32), .in_valid(iv32), .in_ready(ir32),
        .in_instr(ins32), .in_pc(ipc32), .out_valid(ov32), .out_ready(ordy32),
        .out_pc(opc32), .out_opcode(oop32), .out_func3(of3_32), .out_func7(of7_32),
        .out_rs1(ors1_32), .out_rs2(ors2_32), .out_rd(ord32), .out_imm(oimm32),
        .out_illegal(oill32)
    );

    decode_stage #(.XLEN(64), .DEPTH(2), .ENABLE_M(1), .ENABLE_FENCE(1)) u64 (
        .clk(clk), .reset_n(rn), .flush(fl64), .in_valid(iv64), .in_ready(ir64),
        .in_instr(ins64), .in_pc(ipc64), .out_valid(ov64), .out_ready(ordy64),
        .out_pc(opc64), .out_opcode(oop64), .out_func3(of3_64), .out_func7(of7_64),
        .out_rs1(ors1_64), .out_rs2(ors2_64), .out_rd(ord64), .out_imm(oimm64),
        .out_illegal(oill64)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check_entry(input string t, input exp_t e, input logic [63:0] pc,
                               input logic [63:0] imm, input logic [6:0] opc,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic ill);
        chk({t, "_pc"}, pc, e.pc);
        chk({t, "_opcode"}, 64'(opc), 64'(e.ins[6:0]));
        chk({t, "_func3"}, 64'(f3), 64'(e.ins[14:12]));
        chk({t, "_func7"}, 64'(f7), 64'(e.ins[31:25]));
        chk({t, "_rs1"}, 64'(rs1), 64'(e.ins[19:15]));
        chk({t, "_rs2"}, 64'(rs2), 64'(e.ins[24:20]));
        chk({t, "_rd"}, 64'(rd), 64'(e.ins[11:7]));
        chk({t, "_imm"}, imm, e.imm);
        chk({t, "_illegal"}, 64'(ill), 64'(e.ill));
    endtask

    always @(negedge clk) begin
        if (rn && ov32 && ordy32 && !fl32) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d32_unexpected got_pc=%h exp=none", opc32);
            end else begin
                e32 = q32.pop_front();
                check_entry("d32", e32, 64'(opc32), 64'(oimm32), oop32, of3_32, of7_32,
                            ors1_32, ors2_32, ord32, oill32);
            end
        end
    end

    always @(negedge clk) begin
        if (rn && ov64 && ordy64 && !fl64) begin
            if (q64.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d64_unexpected got_pc=%h exp=none", opc64);
            end else begin
                e64 = q64.pop_front();
                check_entry("d64", e64, opc64, oimm64, oop64, of3_64, of7_64,
                            ors1_64, ors2_64, ord64, oill64);
            end
        end
    end

    task automatic push32(input logic [31:0] ins, input logic [31:0] imm, input logic ill);
        int n = 0;
        iv32 = 1'b1;
        ins32 = ins;
        ipc32 = nxt_pc[31:0];
        while (!ir32 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ir32) begin
            chk("push32_timeout", 64'(ir32), 64'd1);
        end else begin
            @(posedge clk);
            q32.push_back('{{32'b0, nxt_pc[31:0]}, ins, {32'b0, imm}, ill});
            nxt_pc += 4;
            #1;
        end
        iv32 = 1'b0;
    endtask

    task automatic push64(input logic [31:0] ins, input logic [63:0] imm, input logic ill);
        int n = 0;
        iv64 = 1'b1;
        ins64 = ins;
        ipc64 = nxt_pc;
        while (!ir64 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ir64) begin
            chk("push64_timeout", 64'(ir64), 64'd1);
        end else begin
            @(posedge clk);
            q64.push_back('{nxt_pc, ins, imm, ill});
            nxt_pc += 4;
            #1;
        end
        iv64 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    vec_t tbl[] = '{
        '{32'h00000000, 32'h0,        1'b1, 64'h0,                 1'b1},
        '{32'h02208033, 32'h0,        1'b1, 64'h0,                 1'b0},
        '{32'h0000003B, 32'h0,        1'b1, 64'h0,                 1'b0},
        '{32'h0010009B, 32'h0,        1'b1, 64'h1,                 1'b0},
        '{32'h0000200F, 32'h0,        1'b1, 64'h0,                 1'b1},
        '{32'h0000000F, 32'h0,        1'b0, 64'h0,                 1'b0},
        '{32'h00C12083, 32'hC,        1'b0, 64'hC,                 1'b0},
        '{32'h00C17083, 32'h0,        1'b1, 64'h0,                 1'b1},
        '{32'h00C13083, 32'h0,        1'b1, 64'hC,                 1'b0},
        '{32'h0000B423, 32'h0,        1'b1, 64'h8,                 1'b0},
        '{32'h008000EF, 32'h8,        1'b0, 64'h8,                 1'b0},
        '{32'h000090E7, 32'h0,        1'b1, 64'h0,                 1'b1},
        '{32'h02109093, 32'h0,        1'b1, 64'h21,                1'b0},
        '{32'h4000D093, 32'h400,      1'b0, 64'h400,               1'b0},
        '{32'h30529073, 32'h305,      1'b0, 64'h305,               1'b0},
        '{32'h00000073, 32'h0,        1'b0, 64'h0,                 1'b0},
        '{32'h0000A063, 32'h0,        1'b1, 64'h0,                 1'b1},
        '{32'h40208033, 32'h0,        1'b0, 64'h0,                 1'b0},
        '{32'h4020C033, 32'h0,        1'b1, 64'h0,                 1'b1},
        '{32'h800000B7, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000,  1'b0},
        '{32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC,  1'b0}
    };

    initial begin
        logic [63:0] pa;
        rn = 1'b0;
        fl32 = 1'b0; fl64 = 1'b0;
        iv32 = 1'b0; iv64 = 1'b0;
        ins32 = '0; ins64 = '0; ipc32 = '0; ipc64 = '0;
        ordy32 = 1'b0; ordy64 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid32", 64'(ov32), 64'd0);
        chk("rst_ready32", 64'(ir32), 64'd1);
        chk("rst_imm32", 64'(oimm32), 64'd0);
        chk("rst_pc32", 64'(opc32), 64'd0);
        chk("rst_opcode32", 64'(oop32), 64'd0);
        chk("rst_valid64", 64'(ov64), 64'd0);
        chk("rst_ready64", 64'(ir64), 64'd1);
        chk("rst_imm64", oimm64, 64'd0);
        rn = 1'b1;
        @(posedge clk);
        #1;

        ordy32 = 1'b1;
        ordy64 = 1'b1;
        push32(32'hFFF00093, 32'hFFFFFFFF, 1'b0);
        chk("lat_valid", 64'(ov32), 64'd1);
        @(posedge clk);
        #1;
        chk("after_pop_valid", 64'(ov32), 64'd0);
        chk("after_pop_hold_imm", 64'(oimm32), 64'hFFFFFFFF);

        push32(32'h0020A423, 32'h00000008, 1'b0);
        push32(32'hFE000EE3, 32'hFFFFFFFC, 1'b0);
        push64(32'h800000B7, 64'hFFFFFFFF80000000, 1'b0);
        push32(32'h0000003B, 32'h0, 1'b1);
        drain();

        for (int i = 0; i < tbl.size(); i++) begin
            push32(tbl[i].ins, tbl[i].imm32, tbl[i].ill32);
            push64(tbl[i].ins, tbl[i].imm64, tbl[i].ill64);
        end
        drain();

        ordy32 = 1'b0;
        pa = nxt_pc;
        push32(32'h00100093, 32'h1, 1'b0);
        push32(32'h00200113, 32'h2, 1'b0);
        chk("full_ready", 64'(ir32), 64'd0);
        fork
            push32(32'h00300193, 32'h3, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("held_ready", 64'(ir32), 64'd0);
                chk("held_head_pc", 64'(opc32), pa);
                chk("held_valid", 64'(ov32), 64'd1);
                ordy32 = 1'b1;
            end
        join
        drain();

        ordy32 = 1'b0;
        push32(32'h00400213, 32'h4, 1'b0);
        push32(32'h00500293, 32'h5, 1'b0);
        fl32 = 1'b1;
        ordy32 = 1'b1;
        iv32 = 1'b1;
        ins32 = 32'h00600313;
        @(posedge clk);
        #1;
        fl32 = 1'b0;
        iv32 = 1'b0;
        q32.delete();
        chk("flush_full_valid", 64'(ov32), 64'd0);
        chk("flush_full_ready", 64'(ir32), 64'd1);

        ordy32 = 1'b0;
        push32(32'h00700393, 32'h7, 1'b0);
        fl32 = 1'b1;
        iv32 = 1'b1;
        ins32 = 32'h00800413;
        @(posedge clk);
        #1;
        fl32 = 1'b0;
        iv32 = 1'b0;
        q32.delete();
        chk("flush_push_valid", 64'(ov32), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("flush_nopush_valid", 64'(ov32), 64'd0);

        push32(32'h00900493, 32'h9, 1'b0);
        push32(32'h00A00513, 32'hA, 1'b0);
        #2;
        rn = 1'b0;
        #1;
        q32.delete();
        chk("arst_valid", 64'(ov32), 64'd0);
        chk("arst_ready", 64'(ir32), 64'd1);
        chk("arst_imm", 64'(oimm32), 64'd0);
        chk("arst_pc", 64'(opc32), 64'd0);
        @(posedge clk);
        #1;
        rn = 1'b1;
        @(posedge clk);
        #1;
        ordy32 = 1'b1;
        push32(32'h00B00593, 32'hB, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
